fp_mul_issue: RTL
=================

# fp_mul_issue

Operand issue stage sitting directly upstream of the floating-point multiplier datapath (`fp_mul`). It accepts packed operand pairs over a valid/ready stream and unpacks each pair into sign/exponent/fraction fields. It flushes subnormals to signed zero and classifies IEEE special cases, so the multiplier only ever sees normal numbers or exact zeros. A 2-entry skid FIFO decouples upstream and downstream back-pressure while sustaining one pair per cycle.

## Interface
Parameters:
- `EXP_WIDTH`, 8, exponent width (bfloat16 default).
- `FRAC_WIDTH`, 7, stored fraction width.
- W = 1+EXP_WIDTH+FRAC_WIDTH (derived, 16 by default).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  stage can accept a pair this cycle.
- `in_op1`, `in_op2`  in  W  packed operands {sign, exp, frac}.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream consumes head this cycle.
- `out_op1_sign`, `out_op2_sign`  out  1  operand signs.
- `out_op1_exp`, `out_op2_exp`  out  EXP_WIDTH  exponents, 0 after flush.
- `out_op1_frac`, `out_op2_frac`  out  FRAC_WIDTH  fractions, 0 after flush.
- `out_special`  out  1  result is fixed by special-case rules; downstream selects `out_special_val`.
- `out_special_val`  out  W  packed special result, 0 when `out_special`=0.

## Operation
- Transfers:
  - Input transfer when `in_valid && in_ready` at a rising edge.
  - Output transfer when `out_valid && out_ready`.
- Per-operand classification, combinational before the FIFO write:
  - ZERO: exp==0. Covers true zero and subnormal; subnormals are flushed, frac forced to 0, sign kept.
  - INF: exp all-ones, frac==0.
  - NAN: exp all-ones, frac!=0.
  - NORM: otherwise.
- Special rules, applied in priority order:
  - Either operand NAN, or INF×ZERO in either order → `out_special`=1, value = canonical qNaN {0, all-ones, 1 followed by zeros}.
  - Either operand INF (other not ZERO) → `out_special`=1, value = {s1^s2, all-ones, zeros}.
  - Otherwise `out_special`=0, value 0.
- Field passthrough: fields are passed through unchanged, post-flush, even when `out_special`=1.
- FIFO states:
  - EMPTY (count 0): push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push+pop → ONE.
  - FULL: pop → ONE; push is impossible.
- `in_ready` = (count != 2), driven from registered state only, with no combinational path from `out_ready`.
- `out_valid` = (count != 0). Outputs are driven from the head entry register.
- Order is strictly preserved.

## Timing
- Latency: a pair accepted at edge t appears on the outputs with `out_valid`=1 after edge t (cycle t+1), when the FIFO was empty.
- Throughput: 1 pair/cycle sustained with `out_ready` held high.
- Back-pressure:
  - With `out_ready` low, at most 2 pairs are absorbed, then `in_ready` drops the cycle after the second accept.
  - `in_ready` rises the cycle after the first pop from FULL.
- Simultaneous push+pop: in ONE, the head is replaced by the new entry at the same edge. In FULL, the pop frees a slot, but `in_ready` (registered) was 0 that cycle, so no push occurs.
- Reset state: count=0, `out_valid`=0, `in_ready`=1, all data outputs 0.
- Reset mid-operation discards all buffered pairs immediately; no partial output follows.
- Outputs hold stable while `out_valid && !out_ready`.

## Structure
- Shared package `fpu_pkg` holds:
  - `fp_class_e` enum {ZERO, NORM, INF, NAN}.
  - Default widths.
  - Canonical qNaN and infinity constant functions parameterised by EXP_WIDTH/FRAC_WIDTH.
  - Packed struct for an unpacked operand {sign, exp, frac, class}.
- One sub-module is natural: `fp_classify`, a combinational single-operand flush and classify block, instantiated twice.
- The FIFO stays inline: 2 entry registers plus a head pointer and a 2-bit count.

## Test plan
- Stream 0x3F80×0x4000, then 0xC040×0x3F00, `out_ready`=1 → two outputs on consecutive cycles with fields (0,0x7F,0)/(0,0x80,0) and (1,0x80,0x40)/(0,0x7E,0), `out_special`=0, latency 1.
- 0x0001×0x3F80 (subnormal) → op1 exp=0 frac=0 sign=0, `out_special`=0; 0x8001 → sign=1, exp=0, frac=0.
- 0x7F80×0x0000 → `out_special`=1, value 0x7FC0; 0xFF80×0x4000 → value 0xFF80; 0x7FC1×0x3F80 → value 0x7FC0.
- `out_ready`=0 with 3 consecutive `in_valid` → 2 accepted, `in_ready`=0 from the cycle after the 2nd accept. Raising `out_ready` then drains in order, and the 3rd pair is accepted one cycle after the first pop.
- Random valid/ready toggling over 10k pairs → scoreboard shows no loss, no duplication, order preserved, and outputs stable while stalled.
- Assert `rst` while FULL → same cycle `out_valid`=0, `in_ready`=1, outputs 0; the next accepted pair emerges with latency 1.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand classes, default widths, special-value
// constants and the unpacked-operand record used by the issue stage.
package fpu_pkg;

  localparam int DEF_EXP_WIDTH  = 8;
  localparam int DEF_FRAC_WIDTH = 7;

  // Operand class after subnormal flush.
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  // Skid FIFO occupancy; the encoding equals the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  // Unpacked operand at the default widths.
  typedef struct packed {
    logic                      sign;
    logic [DEF_EXP_WIDTH-1:0]  exp;
    logic [DEF_FRAC_WIDTH-1:0] frac;
    fp_class_e                 cls;
  } fp_operand_t;

  // Canonical quiet NaN {0, all-ones, 1 followed by zeros}, right-aligned in
  // 64 bits; callers truncate to their packed width.
  function automatic logic [63:0] qnan_val(input int unsigned exp_w,
                                           input int unsigned frac_w);
    logic [63:0] ones_exp;
    ones_exp = (64'd1 << exp_w) - 64'd1;
    return (ones_exp << frac_w) | (64'd1 << (frac_w - 1));
  endfunction

  // Positive infinity {0, all-ones, zeros}, right-aligned in 64 bits.
  function automatic logic [63:0] inf_val(input int unsigned exp_w,
                                          input int unsigned frac_w);
    logic [63:0] ones_exp;
    ones_exp = (64'd1 << exp_w) - 64'd1;
    return ones_exp << frac_w;
  endfunction

endpackage

// File: rtl/fp_mul_issue_if.sv
// Operand-pair stream into the issue stage and unpacked stream out of it.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// The producer holds valid and its payload stable until that transfer; the
// consumer may raise or drop ready freely. in_ready depends only on
// registered state, never combinationally on out_ready.
interface fp_mul_issue_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7
);
  localparam int W = 1 + EXP_WIDTH + FRAC_WIDTH;

  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_op1;
  logic [W-1:0]          in_op2;

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_op1_sign;
  logic                  out_op2_sign;
  logic [EXP_WIDTH-1:0]  out_op1_exp;
  logic [EXP_WIDTH-1:0]  out_op2_exp;
  logic [FRAC_WIDTH-1:0] out_op1_frac;
  logic [FRAC_WIDTH-1:0] out_op2_frac;
  logic                  out_special;
  logic [W-1:0]          out_special_val;

  // Environment side: drives operand pairs and consumes results.
  modport master (
    output in_valid, in_op1, in_op2, out_ready,
    input  in_ready, out_valid, out_op1_sign, out_op2_sign,
           out_op1_exp, out_op2_exp, out_op1_frac, out_op2_frac,
           out_special, out_special_val
  );

  // Issue stage side.
  modport slave (
    input  in_valid, in_op1, in_op2, out_ready,
    output in_ready, out_valid, out_op1_sign, out_op2_sign,
           out_op1_exp, out_op2_exp, out_op1_frac, out_op2_frac,
           out_special, out_special_val
  );
endinterface

// File: rtl/fp_classify.sv
// Single-operand unpack: splits {sign, exp, frac}, flushes subnormals to a
// signed zero and classifies the result.
module fp_classify
  import fpu_pkg::*;
#(
  parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH
) (
  input  logic [EXP_WIDTH+FRAC_WIDTH:0] op,
  output logic                          sign,
  output logic [EXP_WIDTH-1:0]          exp,
  output logic [FRAC_WIDTH-1:0]         frac,
  output fp_class_e                     cls
);
  localparam int W = 1 + EXP_WIDTH + FRAC_WIDTH;

  logic [EXP_WIDTH-1:0]  raw_exp;
  logic [FRAC_WIDTH-1:0] raw_frac;

  assign raw_exp  = op[W-2:FRAC_WIDTH];
  assign raw_frac = op[FRAC_WIDTH-1:0];

  // Zero exponent covers true zero and subnormal; both leave as exact zero.
  always_comb begin
    sign = op[W-1];
    exp  = raw_exp;
    frac = raw_frac;
    cls  = NORM;
    if (raw_exp == '0) begin
      frac = '0;
      cls  = ZERO;
    end else if (&raw_exp) begin
      cls = (raw_frac == '0) ? INF : NAN;
    end
  end
endmodule

// File: rtl/fp_mul_issue.sv
// Operand issue stage ahead of fp_mul: unpacks and classifies each operand
// pair, resolves NaN/Inf special results, and buffers pairs in a 2-entry
// skid FIFO so upstream ready never depends combinationally on downstream.
module fp_mul_issue
  import fpu_pkg::*;
#(
  parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  fp_mul_issue_if.slave io,
  output fifo_state_e   dbg_state
);
  localparam int W = 1 + EXP_WIDTH + FRAC_WIDTH;

  localparam logic [W-1:0] QNAN    = W'(qnan_val(EXP_WIDTH, FRAC_WIDTH));
  localparam logic [W-1:0] INF_POS = W'(inf_val(EXP_WIDTH, FRAC_WIDTH));

  typedef struct packed {
    logic                  s1;
    logic [EXP_WIDTH-1:0]  e1;
    logic [FRAC_WIDTH-1:0] f1;
    logic                  s2;
    logic [EXP_WIDTH-1:0]  e2;
    logic [FRAC_WIDTH-1:0] f2;
    logic                  special;
    logic [W-1:0]          special_val;
  } entry_t;

  // Operand unpack and classify
  logic                  s1, s2;
  logic [EXP_WIDTH-1:0]  e1, e2;
  logic [FRAC_WIDTH-1:0] f1, f2;
  fp_class_e             c1, c2;

  fp_classify #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_cls1 (
    .op(io.in_op1), .sign(s1), .exp(e1), .frac(f1), .cls(c1)
  );

  fp_classify #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_cls2 (
    .op(io.in_op2), .sign(s2), .exp(e2), .frac(f2), .cls(c2)
  );

  logic nan_case;
  logic inf_case;

  assign nan_case = (c1 == NAN) || (c2 == NAN) ||
                    ((c1 == INF) && (c2 == ZERO)) ||
                    ((c1 == ZERO) && (c2 == INF));
  assign inf_case = (c1 == INF) || (c2 == INF);

  entry_t new_entry;

  // Build the FIFO entry; fields pass through post-flush even when special.
  always_comb begin
    new_entry             = '0;
    new_entry.s1          = s1;
    new_entry.e1          = e1;
    new_entry.f1          = f1;
    new_entry.s2          = s2;
    new_entry.e2          = e2;
    new_entry.f2          = f2;
    if (nan_case) begin
      new_entry.special     = 1'b1;
      new_entry.special_val = QNAN;
    end else if (inf_case) begin
      new_entry.special     = 1'b1;
      new_entry.special_val = {s1 ^ s2, INF_POS[W-2:0]};
    end
  end

  // Skid FIFO
  fifo_state_e state;
  logic        head;
  logic        wr_ptr;
  logic        push;
  logic        pop;
  entry_t      entry_q [2];
  entry_t      head_entry;

  assign io.in_ready  = (state != FULL);
  assign io.out_valid = (state != EMPTY);
  assign push         = io.in_valid && io.in_ready;
  assign pop          = io.out_valid && io.out_ready;
  // Empty writes land at the head; otherwise the slot behind it.
  assign wr_ptr       = (state == EMPTY) ? head : ~head;
  assign head_entry   = entry_q[head];
  assign dbg_state    = state;

  // Occupancy FSM, entry storage and head pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      head       <= 1'b0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      if (push) entry_q[wr_ptr] <= new_entry;
      if (pop)  head <= ~head;
      case (state)
        EMPTY: if (push) state <= ONE;
        ONE: begin
          if (push && !pop)      state <= FULL;
          else if (pop && !push) state <= EMPTY;
        end
        FULL:    if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  assign io.out_op1_sign    = head_entry.s1;
  assign io.out_op1_exp     = head_entry.e1;
  assign io.out_op1_frac    = head_entry.f1;
  assign io.out_op2_sign    = head_entry.s2;
  assign io.out_op2_exp     = head_entry.e2;
  assign io.out_op2_frac    = head_entry.f2;
  assign io.out_special     = head_entry.special;
  assign io.out_special_val = head_entry.special_val;
endmodule
